// File: rtl/qam_demap_sequencer.sv
// qam_demap_sequencer: sequences the 16QAM hard-decision demapper datapath on dclk.
// Optional macro QAM_SEQ_PENDING_EN adds a one-deep pending-symbol flag.
module qam_demap_sequencer #(
  parameter int BITS_PER_SYM = 4,
  parameter int CAL_CYCLES   = 16
) (
  input  logic dclk,
  input  logic rst,
  input  logic enable,
  input  logic calibrate,
  input  logic sym_strobe,
  output logic latch_offset,
  output logic latch_reg,
  output logic shift,
  output logic busy,
  output logic frame_sync,
  output logic overrun
);

  // state       | meaning
  // ST_IDLE     | disabled, waiting for calibrate or enable
  // ST_CAL      | latch_offset held high for CAL_CYCLES cycles
  // ST_WAIT_SYM | enabled, waiting for a symbol strobe (or pending symbol)
  // ST_LATCH    | one-cycle capture pulse to the datapath input register
  // ST_LOAD     | datapath copies input register into output register
  // ST_SHIFT    | output register shifts out BITS_PER_SYM bits
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAL      = 3'd1,
    ST_WAIT_SYM = 3'd2,
    ST_LATCH    = 3'd3,
    ST_LOAD     = 3'd4,
    ST_SHIFT    = 3'd5
  } state_t;

  localparam int BW = $clog2(BITS_PER_SYM + 1);
  localparam int CW = $clog2(CAL_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_SYM - 1);
  localparam logic [CW-1:0] CAL_LAST = CW'(CAL_CYCLES - 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   cal_cnt_q, cal_cnt_d;
  logic            overrun_q, overrun_d;
  logic            pending_q;
  logic            latch_offset_q, latch_reg_q, shift_q, busy_q, frame_sync_q;
  logic            in_symbol;

  assign in_symbol = (state_q == ST_LATCH) || (state_q == ST_LOAD) || (state_q == ST_SHIFT);

`ifdef QAM_SEQ_PENDING_EN
  logic pending_d;
`else
  assign pending_q = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cal_cnt_d = cal_cnt_q;
    overrun_d = overrun_q;
`ifdef QAM_SEQ_PENDING_EN
    pending_d = pending_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (sym_strobe) overrun_d = 1'b1;
        if (calibrate)   state_d = ST_CAL;
        else if (enable) state_d = ST_WAIT_SYM;
      end
      ST_CAL: begin
        if (sym_strobe) overrun_d = 1'b1;
        if (cal_cnt_q == CAL_LAST) state_d = ST_IDLE;
        else                       cal_cnt_d = cal_cnt_q + CW'(1);
      end
      ST_WAIT_SYM: begin
        if (calibrate) begin
          state_d = ST_CAL;
          if (sym_strobe) overrun_d = 1'b1;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else if (sym_strobe || pending_q) begin
          state_d = ST_LATCH;
          // a fresh strobe and a pending symbol together: only one can be taken
          if (sym_strobe && pending_q) overrun_d = 1'b1;
        end
      end
      ST_LATCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) state_d = ST_WAIT_SYM;
        else                       bit_cnt_d = bit_cnt_q + BW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (sym_strobe && in_symbol) begin
`ifdef QAM_SEQ_PENDING_EN
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
`else
      overrun_d = 1'b1;
`endif
    end

    if (state_d != state_q) begin
      bit_cnt_d = '0;
      cal_cnt_d = '0;
    end

`ifdef QAM_SEQ_PENDING_EN
    // any exit from WAIT_SYM either services or discards the pending symbol
    if ((state_q == ST_WAIT_SYM) && (state_d != ST_WAIT_SYM)) pending_d = 1'b0;
`endif
  end

  always_ff @(posedge dclk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      cal_cnt_q      <= '0;
      overrun_q      <= 1'b0;
      latch_offset_q <= 1'b0;
      latch_reg_q    <= 1'b0;
      shift_q        <= 1'b0;
      busy_q         <= 1'b0;
      frame_sync_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      cal_cnt_q      <= cal_cnt_d;
      overrun_q      <= overrun_d;
      latch_offset_q <= (state_d == ST_CAL);
      latch_reg_q    <= (state_d == ST_LATCH);
      shift_q        <= (state_d == ST_SHIFT);
      busy_q         <= (state_d != ST_IDLE) && (state_d != ST_WAIT_SYM);
      frame_sync_q   <= (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
    end
  end

`ifdef QAM_SEQ_PENDING_EN
  always_ff @(posedge dclk) begin
    if (!rst) pending_q <= 1'b0;
    else      pending_q <= pending_d;
  end
`endif

  assign latch_offset = latch_offset_q;
  assign latch_reg    = latch_reg_q;
  assign shift        = shift_q;
  assign busy         = busy_q;
  assign frame_sync   = frame_sync_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_qam_demap_sequencer.sv
// Testbench for qam_demap_sequencer: directed steps plus random traffic against a
// timeline model (symbol/calibration start cycle plus offset arithmetic).
module tb_qam_demap_sequencer;

  localparam int B    = 4;
  localparam int CALN = 16;

  logic dclk = 1'b0;
  logic rst, enable, calibrate, sym_strobe;
  logic latch_offset, latch_reg, shift, busy, frame_sync, overrun;

  int checks = 0;
  int errors = 0;

  typedef enum int {ACT_NONE, ACT_CAL, ACT_SYM} act_t;
  act_t act    = ACT_NONE;
  int   t0     = 0;
  bit   listen = 1'b0;
  bit   pend   = 1'b0;
  bit   ovr    = 1'b0;
  int   cyc    = 0;

  qam_demap_sequencer #(.BITS_PER_SYM(B), .CAL_CYCLES(CALN)) dut (
    .dclk(dclk), .rst(rst), .enable(enable), .calibrate(calibrate),
    .sym_strobe(sym_strobe), .latch_offset(latch_offset), .latch_reg(latch_reg),
    .shift(shift), .busy(busy), .frame_sync(frame_sync), .overrun(overrun)
  );

  always #5 dclk = ~dclk;

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance the timeline by the cycle that ends at this edge.
  task automatic model_edge();
    int k;
    k = cyc - t0;
    if (!rst) begin
      act = ACT_NONE; listen = 1'b0; pend = 1'b0; ovr = 1'b0;
    end else if (act == ACT_NONE) begin
      if (!listen) begin
        if (sym_strobe) ovr = 1'b1;
        if (calibrate) begin act = ACT_CAL; t0 = cyc; end
        else if (enable) listen = 1'b1;
      end else begin
        if (calibrate) begin
          if (sym_strobe) ovr = 1'b1;
          act = ACT_CAL; t0 = cyc; listen = 1'b0; pend = 1'b0;
        end else if (!enable) begin
          listen = 1'b0; pend = 1'b0;
        end else if (sym_strobe || pend) begin
          if (sym_strobe && pend) ovr = 1'b1;
          act = ACT_SYM; t0 = cyc; pend = 1'b0;
        end
      end
    end else if (act == ACT_CAL) begin
      if (sym_strobe) ovr = 1'b1;
      if (k == CALN) begin act = ACT_NONE; listen = 1'b0; end
    end else begin
      if (sym_strobe) begin
`ifdef QAM_SEQ_PENDING_EN
        if (pend) ovr = 1'b1;
        else      pend = 1'b1;
`else
        ovr = 1'b1;
`endif
      end
      if (k == B + 2) begin act = ACT_NONE; listen = 1'b1; end
    end
  endtask

  task automatic compare();
    int k;
    k = cyc - t0;
    check("latch_offset", latch_offset, act == ACT_CAL);
    check("latch_reg",    latch_reg,    (act == ACT_SYM) && (k == 1));
    check("shift",        shift,        (act == ACT_SYM) && (k >= 3));
    check("frame_sync",   frame_sync,   (act == ACT_SYM) && (k == 3));
    check("busy",         busy,         act != ACT_NONE);
    check("overrun",      overrun,      ovr);
  endtask

  task automatic step();
    @(posedge dclk);
    model_edge();
    cyc++;
    #1;
    compare();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_strobe();
    sym_strobe = 1'b1;
    step();
    sym_strobe = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    run(n);
    rst = 1'b1;
  endtask

  initial begin
    int n_lo, n_sh, n_fs;
    rst = 1'b0; enable = 1'b1; calibrate = 1'b1; sym_strobe = 1'b0;

    // reset held with enable and calibrate high
    run(3);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    step();
    check("cal_after_reset", latch_offset, 1'b1);
    calibrate = 1'b0;

    // calibration length
    n_lo = 1;
    for (int i = 0; i < CALN + 6; i++) begin
      step();
      if (latch_offset === 1'b1) n_lo++;
    end
    check_int("cal_length", n_lo, CALN);

    // single symbol: count shift cycles and frame_sync pulses
    run(2);
    pulse_strobe();
    n_sh = 0; n_fs = 0;
    for (int i = 0; i < B + 6; i++) begin
      step();
      if (shift === 1'b1) n_sh++;
      if (frame_sync === 1'b1) n_fs++;
    end
    check_int("shift_count", n_sh, B);
    check_int("frame_sync_count", n_fs, 1);

    // back-to-back at the minimum period: no loss
    for (int s = 0; s < 4; s++) begin
      pulse_strobe();
      run(B + 2);
    end
    run(3);
    check("min_period_no_overrun", overrun, 1'b0);

    // second strobe during LOAD, third during SHIFT
    pulse_strobe();
    step();
    pulse_strobe();
`ifdef QAM_SEQ_PENDING_EN
    run(1);
    check("pending_no_overrun", overrun, 1'b0);
    pulse_strobe();
    run(1);
    check("pending_full_overrun", overrun, 1'b1);
`else
    run(1);
    check("strobe_in_load_overrun", overrun, 1'b1);
`endif
    run(2 * B + 8);

    // strobe and calibrate together in WAIT_SYM
    do_reset(2);
    run(3);
    sym_strobe = 1'b1; calibrate = 1'b1;
    step();
    sym_strobe = 1'b0; calibrate = 1'b0;
    check("prio_cal", latch_offset, 1'b1);
    check("prio_no_latch", latch_reg, 1'b0);
    check("prio_overrun", overrun, 1'b1);
    run(CALN + 4);

    // enable drops at the second shift cycle
    do_reset(2);
    run(3);
    pulse_strobe();
    run(3);
    enable = 1'b0;
    run(B + 4);
    check("en_drop_idle", busy, 1'b0);

    // reset at the second shift cycle clears overrun
    sym_strobe = 1'b1;
    step();
    sym_strobe = 1'b0;
    enable = 1'b1;
    run(2);
    pulse_strobe();
    run(3);
    check("pre_reset_shift", shift, 1'b1);
    rst = 1'b0;
    step();
    check("reset_mid_shift", shift, 1'b0);
    check("reset_clears_overrun", overrun, 1'b0);
    rst = 1'b1;
    run(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) != 0);
      calibrate  = ($urandom_range(0, 49) == 0);
      sym_strobe = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
